// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Shared encodings for the multi-cycle RV32I controller:
//                FSM states, opcodes, ALU / immediate / mux select codes.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_ctrl_pkg;

    // Controller states, one per datapath phase
    typedef enum logic [3:0] {
        START    = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        OPIMM    = 4'd3,
        ALUWB    = 4'd4,
        MEMADR   = 4'd5,
        MEMRD    = 4'd6,
        MEMWB    = 4'd7,
        MEMWR    = 4'd8,
        BRANCH   = 4'd9,
        JAL_LINK = 4'd10,
        JAL_JUMP = 4'd11,
        ILLEGAL  = 4'd12
    } state_t;

    // Supported major opcodes (instr[6:0])
    localparam logic [6:0] OPC_OP_IMM = 7'd19;
    localparam logic [6:0] OPC_LOAD   = 7'd3;
    localparam logic [6:0] OPC_STORE  = 7'd35;
    localparam logic [6:0] OPC_BRANCH = 7'd99;
    localparam logic [6:0] OPC_JAL    = 7'd111;

    // ALU operations driven by the controller itself
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b111;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_U = 3'b010;
    localparam logic [2:0] IMM_B = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    // ALU operand A sources
    localparam logic [1:0] SRC_A_PC    = 2'd0;
    localparam logic [1:0] SRC_A_RS1   = 2'd1;
    localparam logic [1:0] SRC_A_OLDPC = 2'd2;

    // ALU operand B sources
    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    // Result mux sources
    localparam logic [1:0] RES_ALUOUT  = 2'd0;
    localparam logic [1:0] RES_MEMDATA = 2'd1;
    localparam logic [1:0] RES_ALU     = 2'd2;

    // First execution state for a given opcode; anything unknown traps
    function automatic state_t decode_dispatch(input logic [6:0] opcode);
        state_t nxt;
        case (opcode)
            OPC_OP_IMM:          nxt = OPIMM;
            OPC_LOAD, OPC_STORE: nxt = MEMADR;
            OPC_BRANCH:          nxt = BRANCH;
            OPC_JAL:             nxt = JAL_LINK;
            default:             nxt = ILLEGAL;
        endcase
        return nxt;
    endfunction

    // DECODE precomputes the jump target for JAL, otherwise the branch target
    function automatic logic [2:0] decode_immsrc(input logic [6:0] opcode);
        return (opcode == OPC_JAL) ? IMM_J : IMM_B;
    endfunction

endpackage : cpu_ctrl_pkg
`default_nettype wire

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller_if
//  Description : Bundle between the multi-cycle controller (master) and the
//                datapath / memory port (slave): instruction and status in,
//                enables, handshake and mux selects out.
//  Revision    : 1.0  initial release
// ============================================================================
interface multicycle_controller_if;

    // Status from the datapath
    logic [31:0] instr;
    logic        eq;
    logic        mem_ready;

    // Memory handshake and write enables
    logic        mem_req;
    logic        mem_we;
    logic        iord;
    logic        ir_we;
    logic        pc_we;
    logic        regwrite;

    // Datapath selects
    logic [1:0]  alusrc_a;
    logic [1:0]  alusrc_b;
    logic [2:0]  aluctrl;
    logic [2:0]  immsrc;
    logic [1:0]  resultsrc;

    // Trap indication
    logic        illegal;

    modport master (
        input  instr, eq, mem_ready,
        output mem_req, mem_we, iord, ir_we, pc_we, regwrite,
               alusrc_a, alusrc_b, aluctrl, immsrc, resultsrc, illegal
    );

    modport slave (
        output instr, eq, mem_ready,
        input  mem_req, mem_we, iord, ir_we, pc_we, regwrite,
               alusrc_a, alusrc_b, aluctrl, immsrc, resultsrc, illegal
    );

endinterface : multicycle_controller_if
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Moore FSM sequencing a multi-cycle RV32I datapath over one
//                shared memory port: fetch, decode, op-imm, load, store,
//                bne-style branch and jal. Outputs are decoded from the state
//                register (plus instr / eq / mem_ready where a phase needs it).
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_controller
    import cpu_ctrl_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    multicycle_controller_if.master        bus
);

    state_t      r_state;
    state_t      w_next_state;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;

    assign w_opcode = bus.instr[6:0];
    assign w_funct3 = bus.instr[14:12];

    // State register; async reset drops any outstanding request immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= START;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection; mem_ready only matters in the memory phases
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            START:    w_next_state = FETCH;
            FETCH:    w_next_state = bus.mem_ready ? DECODE : FETCH;
            DECODE:   w_next_state = decode_dispatch(w_opcode);
            OPIMM:    w_next_state = ALUWB;
            ALUWB:    w_next_state = FETCH;
            MEMADR:   w_next_state = (w_opcode == OPC_LOAD) ? MEMRD : MEMWR;
            MEMRD:    w_next_state = bus.mem_ready ? MEMWB : MEMRD;
            MEMWB:    w_next_state = FETCH;
            MEMWR:    w_next_state = bus.mem_ready ? FETCH : MEMWR;
            BRANCH:   w_next_state = FETCH;
            JAL_LINK: w_next_state = JAL_JUMP;
            JAL_JUMP: w_next_state = FETCH;
            ILLEGAL:  w_next_state = ILLEGAL;
            default:  w_next_state = START;
        endcase
    end

    // Control decode: everything idles at zero unless the phase asserts it
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.iord      = 1'b0;
        bus.ir_we     = 1'b0;
        bus.pc_we     = 1'b0;
        bus.regwrite  = 1'b0;
        bus.alusrc_a  = SRC_A_PC;
        bus.alusrc_b  = SRC_B_RS2;
        bus.aluctrl   = ALU_ADD;
        bus.immsrc    = IMM_I;
        bus.resultsrc = RES_ALUOUT;
        bus.illegal   = 1'b0;

        case (r_state)
            FETCH: begin
                // Read at PC while the ALU forms PC+4; commit both on ready
                bus.mem_req   = 1'b1;
                bus.iord      = 1'b0;
                bus.alusrc_a  = SRC_A_PC;
                bus.alusrc_b  = SRC_B_FOUR;
                bus.aluctrl   = ALU_ADD;
                bus.resultsrc = RES_ALU;
                bus.ir_we     = bus.mem_ready;
                bus.pc_we     = bus.mem_ready;
            end
            DECODE: begin
                // Old PC + immediate lands in the ALU out register as target
                bus.alusrc_a = SRC_A_OLDPC;
                bus.alusrc_b = SRC_B_IMM;
                bus.aluctrl  = ALU_ADD;
                bus.immsrc   = decode_immsrc(w_opcode);
            end
            OPIMM: begin
                bus.alusrc_a = SRC_A_RS1;
                bus.alusrc_b = SRC_B_IMM;
                bus.immsrc   = IMM_I;
                bus.aluctrl  = w_funct3;
            end
            ALUWB: begin
                bus.regwrite  = 1'b1;
                bus.resultsrc = RES_ALUOUT;
            end
            MEMADR: begin
                bus.alusrc_a = SRC_A_RS1;
                bus.alusrc_b = SRC_B_IMM;
                bus.aluctrl  = ALU_ADD;
                bus.immsrc   = (w_opcode == OPC_LOAD) ? IMM_I : IMM_S;
            end
            MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
            end
            MEMWB: begin
                bus.regwrite  = 1'b1;
                bus.resultsrc = RES_MEMDATA;
            end
            MEMWR: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                bus.iord    = 1'b1;
            end
            BRANCH: begin
                // Compare rs1/rs2; taken on inequality, target from ALU out reg
                bus.alusrc_a  = SRC_A_RS1;
                bus.alusrc_b  = SRC_B_RS2;
                bus.aluctrl   = ALU_SUB;
                bus.resultsrc = RES_ALUOUT;
                bus.pc_we     = ~bus.eq;
            end
            JAL_LINK: begin
                // rd <= old PC + 4 straight off the ALU
                bus.alusrc_a  = SRC_A_OLDPC;
                bus.alusrc_b  = SRC_B_FOUR;
                bus.aluctrl   = ALU_ADD;
                bus.resultsrc = RES_ALU;
                bus.regwrite  = 1'b1;
            end
            JAL_JUMP: begin
                // Jump target was captured during DECODE
                bus.pc_we     = 1'b1;
                bus.resultsrc = RES_ALUOUT;
            end
            ILLEGAL: begin
                bus.illegal = 1'b1;
            end
            default: begin
                bus.illegal = 1'b0;
            end
        endcase
    end

endmodule : multicycle_controller
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_controller
//  Description : Self-checking bench for multicycle_controller. Each
//                instruction is expanded into a per-cycle timeline of expected
//                control words from the instruction-level behaviour, then
//                replayed against the DUT with random waits and flags.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic rst;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic        eq;
        logic [31:0] instr;
        logic [18:0] exp;
        logic [63:0] tag;
    } step_t;

    step_t plan[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    // One comparison: count it, report a mismatch
    task automatic check(input logic [63:0] tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %0s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Packed control word: req we iord irwe pcwe rw a b op imm res ill
    function automatic logic [18:0] cw(input logic req, input logic we, input logic iord,
                                       input logic irwe, input logic pcwe, input logic rw,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] op, input logic [2:0] imm,
                                       input logic [1:0] res, input logic ill);
        return {req, we, iord, irwe, pcwe, rw, a, b, op, imm, res, ill};
    endfunction

    function automatic logic [18:0] observed();
        return {bus.mem_req, bus.mem_we, bus.iord, bus.ir_we, bus.pc_we, bus.regwrite,
                bus.alusrc_a, bus.alusrc_b, bus.aluctrl, bus.immsrc, bus.resultsrc, bus.illegal};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add(input logic ready, input logic eq, input logic [31:0] instr,
                       input logic [18:0] exp, input logic [63:0] tag);
        step_t s;
        s.ready = ready; s.eq = eq; s.instr = instr; s.exp = exp; s.tag = tag;
        plan.push_back(s);
    endtask

    // Expand one instruction into its expected cycle-by-cycle behaviour.
    // wf/wm: wait cycles on the fetch / data access; eq_mode 0/1 forced, 2 random.
    task automatic build(input logic [31:0] instr, input int wf, input int wm, input int eq_mode);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] junk;
        logic        r;
        logic        e;
        opc = instr[6:0];
        f3  = instr[14:12];
        for (int k = 0; k <= wf; k++) begin
            r    = (k == wf);
            junk = $urandom();
            add(r, rb(), junk, cw(1,0,0, r,r,0, 2'd0,2'd2, 3'd0,3'd0, 2'd2, 0), "fetch");
        end
        add(rb(), rb(), instr,
            cw(0,0,0, 0,0,0, 2'd2,2'd1, 3'd0, (opc == 7'd111) ? 3'd4 : 3'd3, 2'd0, 0), "decode");
        case (opc)
            7'd19: begin
                add(rb(), rb(), instr, cw(0,0,0, 0,0,0, 2'd1,2'd1, f3,3'd0, 2'd0, 0), "opimm");
                add(rb(), rb(), instr, cw(0,0,0, 0,0,1, 2'd0,2'd0, 3'd0,3'd0, 2'd0, 0), "aluwb");
            end
            7'd3, 7'd35: begin
                add(rb(), rb(), instr,
                    cw(0,0,0, 0,0,0, 2'd1,2'd1, 3'd0, (opc == 7'd3) ? 3'd0 : 3'd1, 2'd0, 0), "memadr");
                for (int k = 0; k <= wm; k++) begin
                    r = (k == wm);
                    if (opc == 7'd3)
                        add(r, rb(), instr, cw(1,0,1, 0,0,0, 2'd0,2'd0, 3'd0,3'd0, 2'd0, 0), "memrd");
                    else
                        add(r, rb(), instr, cw(1,1,1, 0,0,0, 2'd0,2'd0, 3'd0,3'd0, 2'd0, 0), "memwr");
                end
                if (opc == 7'd3)
                    add(rb(), rb(), instr, cw(0,0,0, 0,0,1, 2'd0,2'd0, 3'd0,3'd0, 2'd1, 0), "memwb");
            end
            7'd99: begin
                e = (eq_mode == 2) ? rb() : eq_mode[0];
                add(rb(), e, instr, cw(0,0,0, 0,!e,0, 2'd1,2'd0, 3'd7,3'd0, 2'd0, 0), "branch");
            end
            7'd111: begin
                add(rb(), rb(), instr, cw(0,0,0, 0,0,1, 2'd2,2'd2, 3'd0,3'd0, 2'd2, 0), "jallink");
                add(rb(), rb(), instr, cw(0,0,0, 0,1,0, 2'd0,2'd0, 3'd0,3'd0, 2'd0, 0), "jaljump");
            end
            default: begin
                for (int k = 0; k < 6; k++)
                    add(rb(), rb(), instr, cw(0,0,0, 0,0,0, 2'd0,2'd0, 3'd0,3'd0, 2'd0, 1), "illegal");
            end
        endcase
    endtask

    // Replay the plan: drive just after the edge, sample mid-cycle
    task automatic run_plan();
        step_t s;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            @(posedge clk);
            #1;
            bus.mem_ready = s.ready;
            bus.eq        = s.eq;
            bus.instr     = s.instr;
            @(negedge clk);
            check(s.tag, 32'(observed()), 32'(s.exp));
        end
    endtask

    logic [6:0]  opcs [5] = '{7'd19, 7'd3, 7'd35, 7'd99, 7'd111};
    logic [31:0] rnd_word;

    initial begin
        rst           = 1'b1;
        bus.mem_ready = 1'b0;
        bus.eq        = 1'b0;
        bus.instr     = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", 32'(observed()), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("start", 32'(observed()), 32'h0);

        // Directed: addi, lw with 3 waits, bne taken / not taken, sw, jal
        build(32'h00500093, 0, 0, 2);
        build(32'h0000A103, 0, 3, 2);
        build(32'h00209463, 0, 0, 0);
        build(32'h00209463, 0, 0, 1);
        build(32'h0020A023, 0, 0, 2);
        build(32'h0080006F, 1, 0, 2);
        run_plan();

        // Reset while a fetch is waiting on memory
        @(posedge clk);
        #1 bus.mem_ready = 1'b0;
        @(negedge clk);
        check("rfetch", 32'(observed()), 32'(cw(1,0,0, 0,0,0, 2'd0,2'd2, 3'd0,3'd0, 2'd2, 0)));
        #2 rst = 1'b1;
        #1 check("rstasync", 32'(observed()), 32'h0);
        @(posedge clk);
        #1 check("rsthold", 32'(observed()), 32'h0);
        bus.mem_ready = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("restart", 32'(observed()), 32'h0);

        // Random legal instruction stream
        for (int i = 0; i < 150; i++) begin
            rnd_word = $urandom();
            build({rnd_word[31:7], opcs[$urandom_range(0, 4)]},
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 2);
        end
        run_plan();

        // Unsupported opcode traps until reset
        rnd_word = $urandom();
        build({rnd_word[31:7], 7'h7F}, 0, 0, 2);
        run_plan();
        #2 rst = 1'b1;
        #1 check("illrst", 32'(observed()), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("start2", 32'(observed()), 32'h0);
        build(32'h00500093, 2, 0, 2);
        run_plan();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_multicycle_controller
`default_nettype wire
